// File: rtl/data_memory_responder.sv
// data_memory_responder
//   Word-addressed data memory behind a valid/ready request port. Each
//   accepted request is latched, held for WAIT_CYCLES wait states, then
//   answered with a one-cycle resp_valid pulse. Misaligned or out-of-range
//   addresses are answered with resp_error=1 and never touch storage.
//
// Ports
//   clk        : clock, all state changes on its rising edge
//   reset      : synchronous active-low reset
//   req_valid  : request present
//   req_write  : 1 = store word, 0 = load word
//   req_addr   : byte address
//   req_wdata  : store data
//   req_ready  : request can be accepted this cycle (IDLE)
//   resp_valid : one-cycle response pulse
//   resp_rdata : load data, zero unless resp_valid
//   resp_error : bad address flag, zero unless resp_valid
//   busy       : request in flight
module data_memory_responder #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h10010000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        busy
);

  localparam int unsigned IW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] LIMIT     = BASE_ADDR + 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;

  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        enter_respond;
  logic        op_write;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic [IW-1:0] op_idx;
  logic        op_err;

  logic [31:0] rdata_q;
  logic        err_q;

  assign accept = (state == IDLE) && req_valid;

  // With WAIT_CYCLES=0 the storage access happens on the acceptance edge
  // itself, before the latch holds anything, so the live request is used
  // while IDLE and the latched copy otherwise.
  always_comb begin
    op_write = write_q;
    op_addr  = addr_q;
    op_wdata = wdata_q;
    if (state == IDLE) begin
      op_write = req_write;
      op_addr  = req_addr;
      op_wdata = req_wdata;
    end
    op_idx = IW'((op_addr - BASE_ADDR) >> 2);
    op_err = (op_addr[1:0] != 2'b00) || (op_addr < BASE_ADDR) || (op_addr >= LIMIT);
  end

  // State register, wait counter and registered response fields
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      err_q   <= enter_respond && op_err;
      rdata_q <= (enter_respond && !op_write && !op_err) ? mem[op_idx] : '0;
    end
  end

  // Request latch; only loaded on acceptance
  always_ff @(posedge clk) begin
    if (reset && accept) begin
      write_q <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Storage: not cleared by reset, and a reset edge suppresses the write
  always_ff @(posedge clk) begin
    if (reset && enter_respond && op_write && !op_err) begin
      mem[op_idx] <= op_wdata;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESPOND;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        // Counter reaches 0 on the same edge that moves to RESPOND
        cnt_d = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_d = RESPOND;
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign enter_respond = (state != RESPOND) && (state_d == RESPOND);

  // Outputs
  always_comb begin
    req_ready  = (state == IDLE);
    busy       = (state != IDLE);
    resp_valid = (state == RESPOND);
    resp_rdata = rdata_q;
    resp_error = err_q;
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: one instance with WAIT_CYCLES=2 and one
// with WAIT_CYCLES=0, checked every cycle against a transaction-level model
// (edge-count schedule plus an array memory), with directed literal checks.
module tb_data_memory_responder;

  localparam logic [31:0] BASE = 32'h10010000;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rv, rw, rr, vv, re, bz;
  logic [31:0] ra [2];
  logic [31:0] rwd [2];
  logic [31:0] rd [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_memory_responder #(.WAIT_CYCLES(2), .DEPTH_WORDS(1024), .BASE_ADDR(32'h10010000)) dut_w2 (
    .clk(clk), .reset(reset),
    .req_valid(rv[0]), .req_write(rw[0]), .req_addr(ra[0]), .req_wdata(rwd[0]),
    .req_ready(rr[0]), .resp_valid(vv[0]), .resp_rdata(rd[0]), .resp_error(re[0]),
    .busy(bz[0])
  );

  data_memory_responder #(.WAIT_CYCLES(0), .DEPTH_WORDS(1024), .BASE_ADDR(32'h10010000)) dut_w0 (
    .clk(clk), .reset(reset),
    .req_valid(rv[1]), .req_write(rw[1]), .req_addr(ra[1]), .req_wdata(rwd[1]),
    .req_ready(rr[1]), .resp_valid(vv[1]), .resp_rdata(rd[1]), .resp_error(re[1]),
    .busy(bz[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int wof(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  // ---------------- behavioural model ----------------
  int          e = 0;
  bit          pending [2];
  int          resp_edge [2];
  int          acc_cnt [2];
  logic        lw [2];
  logic [31:0] la [2];
  logic [31:0] lwd [2];
  logic [31:0] mm [2][1024];
  logic        exp_ready [2];
  logic        exp_valid [2];
  logic        exp_err [2];
  logic [31:0] exp_rdata [2];
  bit          chk_en = 0;

  always @(posedge clk) begin
    longint a;
    bit     err;
    int     idx;
    e++;
    for (int i = 0; i < 2; i++) begin
      exp_valid[i] = 0;
      exp_rdata[i] = '0;
      exp_err[i]   = 0;
      if (!reset) begin
        pending[i] = 0;
      end else begin
        if (!pending[i]) begin
          if (rv[i]) begin
            lw[i]        = rw[i];
            la[i]        = ra[i];
            lwd[i]       = rwd[i];
            pending[i]   = 1;
            resp_edge[i] = e + wof(i);
            acc_cnt[i]++;
          end
        end else if (e == resp_edge[i] + 1) begin
          pending[i] = 0;
        end
        if (pending[i] && e == resp_edge[i]) begin
          a   = longint'(la[i]);
          err = (la[i][1:0] != 2'b00) || (a < longint'(BASE)) || (a >= longint'(BASE) + 4096);
          exp_valid[i] = 1;
          exp_err[i]   = err;
          if (!err) begin
            idx = int'((a - longint'(BASE)) / 4);
            if (lw[i]) mm[i][idx] = lwd[i];
            else       exp_rdata[i] = mm[i][idx];
          end
        end
      end
      exp_ready[i] = !pending[i];
    end
    chk_en = 1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("ready%0d", i), 32'(rr[i]), 32'(exp_ready[i]));
        check($sformatf("busy%0d", i),  32'(bz[i]), 32'(!exp_ready[i]));
        check($sformatf("valid%0d", i), 32'(vv[i]), 32'(exp_valid[i]));
        check($sformatf("rdata%0d", i), rd[i],      exp_rdata[i]);
        check($sformatf("error%0d", i), 32'(re[i]), 32'(exp_err[i]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Returns latency in cycles: 1 = response visible in the cycle right after
  // the acceptance edge.
  task automatic issue(input int i, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input bit scramble,
                       output int lat, output logic [31:0] got_rdata, output logic got_err);
    int c0;
    int k;
    c0 = acc_cnt[i];
    lat = -1;
    got_rdata = 'x;
    got_err = 'x;
    @(negedge clk);
    rv[i] = 1'b1; rw[i] = wr; ra[i] = a; rwd[i] = d;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (acc_cnt[i] == c0 && k < 50);
    rv[i] = 1'b0;
    if (acc_cnt[i] == c0) begin
      total++; bad++;
      $display("FAIL accept_timeout%0d: got none want accept within 50 cycles", i);
      return;
    end
    if (scramble) begin
      ra[i]  = $urandom;
      rwd[i] = $urandom;
    end
    lat = 1;
    while (!vv[i] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!vv[i]) begin
      total++; bad++;
      $display("FAIL resp_timeout%0d: got none want resp_valid within 40 cycles", i);
      lat = -1;
      return;
    end
    got_rdata = rd[i];
    got_err   = re[i];
  endtask

  function automatic logic [31:0] pool_addr(input int j);
    return BASE + 32'(4 * ((j < 16) ? j : 992 + j));
  endfunction

  function automatic logic [31:0] err_addr(input int k);
    case (k)
      0: return 32'h10010006;
      1: return 32'h10011000;
      2: return 32'h1000FFFC;
      3: return 32'hFFFFFFFC;
      4: return 32'h10010FFD;
      default: return 32'h00000000;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int cnt_v;
    int cnt_nr;
    logic [31:0] r;
    logic er;

    rv = '0; rw = '0;
    for (int i = 0; i < 2; i++) begin
      ra[i] = '0; rwd[i] = '0;
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_ready0", 32'(rr[0]), 32'd1);
    check("reset_busy0",  32'(bz[0]), 32'd0);
    check("reset_valid1", 32'(vv[1]), 32'd0);

    // Known contents for every word the bench touches
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 32; j++) begin
        logic [31:0] pa;
        pa = pool_addr(j);
        issue(i, 1'b1, pa, 32'hA5000000 + ((pa - BASE) >> 2), 1'b0, lat, r, er);
      end

    // Store then load, WAIT_CYCLES=2
    issue(0, 1'b1, 32'h10010008, 32'hDEADBEEF, 1'b0, lat, r, er);
    check("st_lat", 32'(lat), 32'd3);
    check("st_err", 32'(er), 32'd0);
    check("st_rdata", r, 32'd0);
    issue(0, 1'b0, 32'h10010008, 32'h0, 1'b0, lat, r, er);
    check("ld_data", r, 32'hDEADBEEF);
    check("ld_lat", 32'(lat), 32'd3);

    // Misaligned load, neighbour unchanged
    issue(0, 1'b0, 32'h10010006, 32'h0, 1'b0, lat, r, er);
    check("mis_err", 32'(er), 32'd1);
    check("mis_rdata", r, 32'd0);
    check("mis_lat", 32'(lat), 32'd3);
    issue(0, 1'b0, 32'h10010004, 32'h0, 1'b0, lat, r, er);
    check("nbr_data", r, 32'hA5000001);

    // Range boundaries
    issue(0, 1'b1, 32'h10011000, 32'h11111111, 1'b0, lat, r, er);
    check("oor_hi_err", 32'(er), 32'd1);
    issue(0, 1'b1, 32'h1000FFFC, 32'h22222222, 1'b0, lat, r, er);
    check("oor_lo_err", 32'(er), 32'd1);
    issue(0, 1'b1, 32'h10010FFC, 32'hCAFEF00D, 1'b0, lat, r, er);
    check("last_err", 32'(er), 32'd0);
    issue(0, 1'b0, 32'h10010FFC, 32'h0, 1'b0, lat, r, er);
    check("last_data", r, 32'hCAFEF00D);
    check("last_lerr", 32'(er), 32'd0);

    // Inputs changed after acceptance are ignored
    issue(0, 1'b1, 32'h1001000C, 32'h0BADC0DE, 1'b1, lat, r, er);
    issue(0, 1'b0, 32'h1001000C, 32'h0, 1'b1, lat, r, er);
    check("latch_data", r, 32'h0BADC0DE);

    // Reset during WAIT abandons a store
    @(negedge clk);
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h10010010; rwd[0] = 32'h12345678;
    @(negedge clk);
    rv[0] = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("rst_ready", 32'(rr[0]), 32'd1);
    cnt_v = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (vv[0]) cnt_v++;
    end
    check("rst_noresp", 32'(cnt_v), 32'd0);
    issue(0, 1'b0, 32'h10010010, 32'h0, 1'b0, lat, r, er);
    check("rst_keep", r, 32'hA5000004);

    // WAIT_CYCLES=0: single and back-to-back
    issue(1, 1'b0, 32'h10010008, 32'h0, 1'b0, lat, r, er);
    check("w0_lat", 32'(lat), 32'd1);
    check("w0_data", r, 32'hA5000002);
    @(negedge clk);
    @(negedge clk);
    rv[1] = 1'b1; rw[1] = 1'b1; ra[1] = pool_addr(5); rwd[1] = $urandom;
    cnt_v = 0;
    cnt_nr = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (vv[1]) cnt_v++;
      if (!rr[1]) cnt_nr++;
      rw[1]  = 1'($urandom);
      ra[1]  = pool_addr(int'($urandom_range(0, 31)));
      rwd[1] = $urandom;
    end
    rv[1] = 1'b0;
    check("b2b_pulses", 32'(cnt_v), 32'd4);
    check("b2b_notready", 32'(cnt_nr), 32'd4);
    repeat (2) @(negedge clk);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      int i;
      logic [31:0] a;
      i = int'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = err_addr(int'($urandom_range(0, 5)));
      else                           a = pool_addr(int'($urandom_range(0, 31)));
      issue(i, 1'($urandom), a, $urandom, 1'($urandom), lat, r, er);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before 2ms");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 Parameters SHALL be (one per line: name, default, meaning):
- WAIT_CYCLES, 2, wait states inserted between request acceptance and response (legal range 0..15).
- DEPTH_WORDS, 1024, number of 32-bit words of storage.
- BASE_ADDR, 32'h10010000, byte address of word 0.

REQ-002 Ports SHALL be (one per line: name, direction, width, meaning):
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset; reset=0 sampled at a rising clk edge resets the block.
- req_valid  in  1  datapath presents a memory request.
- req_write  in  1  1 = store word, 0 = load word.
- req_addr  in  32  byte address (the datapath's aluout).
- req_wdata  in  32  store data (the datapath's writedata).
- req_ready  out  1  responder can accept a request this cycle.
- resp_valid  out  1  one-cycle pulse; response is complete.
- resp_rdata  out  32  load data (the datapath's readdata); valid only while resp_valid=1.
- resp_error  out  1  request was misaligned or out of range; valid only while resp_valid=1.
- busy  out  1  a request is in flight (state is not IDLE).

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, WAIT, RESPOND.
REQ-004 In IDLE: req_ready SHALL be 1 and busy SHALL be 0; in all other states req_ready SHALL be 0 and busy SHALL be 1.
REQ-005 A request is accepted on the rising edge where req_valid=1 and req_ready=1; the block SHALL latch req_write, req_addr and req_wdata at that edge. Later changes on req_* SHALL be ignored until the next acceptance.
REQ-006 On acceptance the next state SHALL be WAIT with a 4-bit wait counter loaded with WAIT_CYCLES; if WAIT_CYCLES=0, the next state SHALL be RESPOND directly.
REQ-007 In WAIT the counter SHALL decrement once per cycle; on the edge where it reaches 0 the next state SHALL be RESPOND.
REQ-008 RESPOND SHALL last exactly one cycle with resp_valid=1, then return to IDLE. A request is never accepted in the RESPOND cycle.
REQ-009 Latency SHALL be: resp_valid asserts WAIT_CYCLES+1 cycles after the acceptance edge. The minimum acceptance-to-acceptance spacing is WAIT_CYCLES+2 cycles.
REQ-010 Error condition: req_addr[1:0]!=0, OR req_addr<BASE_ADDR, OR req_addr>=BASE_ADDR+4*DEPTH_WORDS. All comparisons SHALL be 32-bit unsigned.
REQ-011 Word index SHALL be (req_addr-BASE_ADDR)>>2, truncated to clog2(DEPTH_WORDS) bits.
REQ-012 Valid store: the storage word SHALL be written on the edge entering RESPOND. resp_rdata SHALL be 0 and resp_error SHALL be 0.
REQ-013 Valid load: resp_rdata SHALL equal the word's contents as of the edge entering RESPOND. resp_error SHALL be 0.
REQ-014 Error request: no storage write SHALL occur, resp_rdata SHALL be 0, resp_error SHALL be 1, and timing SHALL be unchanged.
REQ-015 Whenever resp_valid=0, resp_rdata and resp_error SHALL be 0.
REQ-016 A load to the address of an immediately preceding store SHALL return the stored data (no stale read).

Reset
REQ-017 reset=0 at a rising edge SHALL force IDLE, clear the wait counter, and drive req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, busy=0 from the following cycle.
REQ-018 Reset SHALL take priority over acceptance and all state transitions. A request in flight SHALL be abandoned with no response; a pending store SHALL NOT be written.
REQ-019 Storage contents SHALL NOT be cleared by reset.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- WAIT_CYCLES=2: store 32'hDEADBEEF to 32'h10010008; accept at edge N -> resp_valid=1 only in cycle N+3, resp_error=0. Then load 32'h10010008 -> resp_rdata=32'hDEADBEEF.
- Load 32'h10010006 (misaligned) -> resp_error=1, resp_rdata=0; a following load of 32'h10010004 shows the word unchanged.
- Store to 32'h10011000 (= BASE+4*1024, out of range) -> resp_error=1. Store to 32'h10010FFC (last word) -> resp_error=0, and a load of it reads back.
- WAIT_CYCLES=0: back-to-back requests held valid -> accepts every 2nd cycle, resp_valid=1 the cycle after each accept; req_ready=0 during the RESPOND cycle.
- Store 32'h12345678 to 32'h10010010, assert reset=0 during WAIT -> no resp_valid, req_ready=1 after reset; a load of 32'h10010010 returns its prior value.
- Change req_addr and req_wdata during WAIT -> the response reflects the latched values only.
